// File: rtl/sort_check_controller.sv
// sort_check_controller
//   Control FSM for the array sort-check datapath. On go it loads the
//   datapath (base/length latch and index clear), then walks the index one
//   step per CHECK cycle until the datapath reports end_of_array (sorted)
//   or inversion_found (unsorted). A watchdog stops a run that never ends.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-low reset
//   go               start request (honoured in IDLE, DONE_* and ERROR)
//   abort            synchronous return to IDLE, clears results
//   inversion_found  datapath: element[index] > element[index+1]
//   end_of_array     datapath: index >= length-1, or length == 0
//   load_input       datapath strobe: latch array base and length
//   load_index       datapath strobe: load the index register
//   select_index     index source: 0 = clear, 1 = increment
//   busy             high in LOAD and CHECK
//   done             high in DONE_SORTED and DONE_UNSORTED
//   sorted           verdict, meaningful while done = 1
//   error            watchdog fired (ERROR state)
//   inversion_index  index of the first inversion of an unsorted run
//   check_count      CHECK cycles in the current/last run, saturating at 63
module sort_check_controller #(
  parameter int IDX_W      = 5,
  parameter int MAX_CHECKS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic             inversion_found,
  input  logic             end_of_array,
  output logic             load_input,
  output logic             load_index,
  output logic             select_index,
  output logic             busy,
  output logic             done,
  output logic             sorted,
  output logic             error,
  output logic [IDX_W-1:0] inversion_index,
  output logic [5:0]       check_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE_SORTED,
    S_DONE_UNSORTED,
    S_ERROR
  } state_t;

  localparam logic [6:0] MAX_CHECKS_C = 7'(MAX_CHECKS);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] shadow_idx_reg, shadow_idx_next;
  logic [IDX_W-1:0] inv_idx_reg, inv_idx_next;
  logic [5:0]       count_reg, count_next;
  logic             sorted_reg, sorted_next;

  // Count as it will read after the current CHECK cycle; the watchdog
  // compares this so that it fires on exactly the MAX_CHECKS-th cycle.
  logic [6:0] count_plus_one;
  logic [5:0] count_sat;

  assign count_plus_one = {1'b0, count_reg} + 7'd1;
  assign count_sat      = (count_reg == 6'd63) ? count_reg : count_reg + 6'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      shadow_idx_reg <= '0;
      inv_idx_reg    <= '0;
      count_reg      <= '0;
      sorted_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shadow_idx_reg <= shadow_idx_next;
      inv_idx_reg    <= inv_idx_next;
      count_reg      <= count_next;
      sorted_reg     <= sorted_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shadow_idx_next = shadow_idx_reg;
    inv_idx_next    = inv_idx_reg;
    count_next      = count_reg;
    sorted_next     = sorted_reg;
    load_input      = 1'b0;
    load_index      = 1'b0;
    select_index    = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    error           = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (go) state_next = S_LOAD;
      end

      S_LOAD: begin
        load_input      = 1'b1;
        load_index      = 1'b1;
        busy            = 1'b1;
        shadow_idx_next = '0;
        count_next      = '0;
        inv_idx_next    = '0;
        sorted_next     = 1'b0;
        state_next      = S_CHECK;
      end

      S_CHECK: begin
        busy       = 1'b1;
        count_next = count_sat;
        // end_of_array first: the pair beyond the last element is not valid.
        if (end_of_array) begin
          state_next  = S_DONE_SORTED;
          sorted_next = 1'b1;
        end else if (inversion_found) begin
          state_next   = S_DONE_UNSORTED;
          sorted_next  = 1'b0;
          inv_idx_next = shadow_idx_reg;
        end else if (count_plus_one == MAX_CHECKS_C) begin
          state_next = S_ERROR;
        end else begin
          // Advance the datapath index and keep our shadow copy in step.
          load_index      = 1'b1;
          select_index    = 1'b1;
          shadow_idx_next = shadow_idx_reg + 1'b1;
        end
      end

      S_DONE_SORTED, S_DONE_UNSORTED: begin
        done = 1'b1;
        if (go) state_next = S_LOAD;
      end

      S_ERROR: begin
        error = 1'b1;
        if (go) state_next = S_LOAD;
      end

      default: state_next = S_IDLE;
    endcase

    // Abort wins over all state logic; strobes are suppressed so the
    // datapath is not disturbed on the way out.
    if (abort) begin
      state_next   = S_IDLE;
      sorted_next  = 1'b0;
      inv_idx_next = '0;
      count_next   = '0;
      load_input   = 1'b0;
      load_index   = 1'b0;
      select_index = 1'b0;
    end
  end

  assign sorted          = sorted_reg;
  assign inversion_index = inv_idx_reg;
  assign check_count     = count_reg;

endmodule

// File: tb/tb_sort_check_controller.sv
module tb_sort_check_controller;

  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             go;
  logic             abort;
  logic             inversion_found;
  logic             end_of_array;
  logic             load_input;
  logic             load_index;
  logic             select_index;
  logic             busy;
  logic             done;
  logic             sorted;
  logic             error;
  logic [IDX_W-1:0] inversion_index;
  logic [5:0]       check_count;

  int checks   = 0;
  int failures = 0;

  sort_check_controller #(.IDX_W(IDX_W), .MAX_CHECKS(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .go              (go),
    .abort           (abort),
    .inversion_found (inversion_found),
    .end_of_array    (end_of_array),
    .load_input      (load_input),
    .load_index      (load_index),
    .select_index    (select_index),
    .busy            (busy),
    .done            (done),
    .sorted          (sorted),
    .error           (error),
    .inversion_index (inversion_index),
    .check_count     (check_count)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; inputs are then changed at +1 and
  // outputs sampled at +2, both well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; go = 1'b1; abort = 1'b0;
    inversion_found = 1'b0; end_of_array = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if ({load_input, load_index, select_index, busy, done, sorted, error} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {load_input, load_index, select_index, busy, done, sorted, error});
    end
    checks++;
    if (inversion_index !== 5'd0 || check_count !== 6'd0) begin
      failures++;
      $display("FAIL reset_regs got inv=%0d cnt=%0d exp inv=0 cnt=0", inversion_index, check_count);
    end
    reset = 1'b1; go = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b err=%b exp 0 0 0", busy, done, error);
    end
    $display("test_reset done");
  endtask

  task automatic test_sorted();
    int n_load;
    int n_inc;
    n_load = 0; n_inc = 0;
    go = 1'b1;
    tick();                       // edge sampling go -> LOAD
    go = 1'b0;
    #1;
    n_load += int'(load_input);
    n_inc  += int'(load_index & select_index);
    checks++;
    if ({load_input, load_index, select_index, busy} !== 4'b1101) begin
      failures++;
      $display("FAIL sorted_load_outputs got=%b exp=1101",
               {load_input, load_index, select_index, busy});
    end
    for (int k = 1; k <= 3; k++) begin
      tick();                     // CHECK cycle k, flags clear
      #1;
      n_load += int'(load_input);
      n_inc  += int'(load_index & select_index);
    end
    tick();                       // CHECK cycle 4
    end_of_array = 1'b1;
    #1;
    n_load += int'(load_input);
    n_inc  += int'(load_index & select_index);
    tick();
    end_of_array = 1'b0;
    #1;
    checks++;
    if (n_load !== 1 || n_inc !== 3) begin
      failures++;
      $display("FAIL sorted_strobes got load=%0d inc=%0d exp load=1 inc=3", n_load, n_inc);
    end
    checks++;
    if (done !== 1'b1 || sorted !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sorted_verdict got done=%b sorted=%b busy=%b exp 1 1 0", done, sorted, busy);
    end
    checks++;
    if (check_count !== 6'd4 || inversion_index !== 5'd0) begin
      failures++;
      $display("FAIL sorted_counts got cnt=%0d inv=%0d exp cnt=4 inv=0", check_count, inversion_index);
    end
    $display("test_sorted done");
  endtask

  task automatic test_unsorted();
    go = 1'b1;
    tick();                       // LOAD
    go = 1'b0;
    tick();                       // CHECK 1, index 0
    tick();                       // CHECK 2, index 1
    tick();                       // CHECK 3, index 2
    inversion_found = 1'b1;
    tick();
    inversion_found = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || sorted !== 1'b0) begin
      failures++;
      $display("FAIL unsorted_verdict got done=%b sorted=%b exp 1 0", done, sorted);
    end
    checks++;
    if (inversion_index !== 5'd2 || check_count !== 6'd3) begin
      failures++;
      $display("FAIL unsorted_result got inv=%0d cnt=%0d exp inv=2 cnt=3", inversion_index, check_count);
    end
    // Results hold while no go arrives, even with flags toggling.
    end_of_array = 1'b1;
    tick();
    tick();
    tick();
    end_of_array = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || sorted !== 1'b0 || inversion_index !== 5'd2 || check_count !== 6'd3) begin
      failures++;
      $display("FAIL unsorted_hold got done=%b sorted=%b inv=%0d cnt=%0d exp 1 0 2 3",
               done, sorted, inversion_index, check_count);
    end
    $display("test_unsorted done");
  endtask

  task automatic test_priority();
    go = 1'b1;
    tick();                       // LOAD
    go = 1'b0;
    tick();                       // CHECK 1
    end_of_array = 1'b1; inversion_found = 1'b1;
    tick();
    end_of_array = 1'b0; inversion_found = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || sorted !== 1'b1 || check_count !== 6'd1 || inversion_index !== 5'd0) begin
      failures++;
      $display("FAIL priority_both got done=%b sorted=%b cnt=%0d inv=%0d exp 1 1 1 0",
               done, sorted, check_count, inversion_index);
    end
    // go held high through the whole run must not restart it.
    go = 1'b1;
    tick();                       // LOAD
    tick();                       // CHECK 1
    tick();                       // CHECK 2
    #1;
    checks++;
    if (busy !== 1'b1 || load_input !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL priority_go_ignored got busy=%b load_input=%b done=%b exp 1 0 0",
               busy, load_input, done);
    end
    tick();                       // CHECK 3
    end_of_array = 1'b1;
    tick();
    end_of_array = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || check_count !== 6'd3) begin
      failures++;
      $display("FAIL priority_go_held got done=%b cnt=%0d exp done=1 cnt=3", done, check_count);
    end
    go = 1'b0;
    tick();
    $display("test_priority done");
  endtask

  task automatic test_abort();
    go = 1'b1;
    tick();                       // LOAD
    go = 1'b0;
    tick();                       // CHECK 1
    tick();                       // CHECK 2
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || check_count !== 6'd0 || error !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b done=%b cnt=%0d err=%b exp 0 0 0 0",
               busy, done, check_count, error);
    end
    tick();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_stays_idle got busy=%b exp 0", busy);
    end
    // Same again with a mid-run reset instead of abort.
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || check_count !== 6'd0 || sorted !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset got busy=%b done=%b cnt=%0d sorted=%b exp 0 0 0 0",
               busy, done, check_count, sorted);
    end
    $display("test_abort done");
  endtask

  task automatic test_watchdog();
    int edges;
    int n_inc;
    bit seen;
    edges = 0; n_inc = 0; seen = 1'b0;
    go = 1'b1;
    tick();                       // LOAD
    go = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      #1;
      n_inc += int'(load_index & select_index);
      tick();
      edges++;
      #1;
      if (error === 1'b1) seen = 1'b1;
    end
    // 1 edge into CHECK plus 32 CHECK cycles; 31 of them increment.
    checks++;
    if (!seen || edges !== 33) begin
      failures++;
      $display("FAIL watchdog_timing got seen=%0d edges=%0d exp seen=1 edges=33", seen, edges);
    end
    checks++;
    if (n_inc !== 31 || check_count !== 6'd32 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_state got inc=%0d cnt=%0d busy=%b done=%b exp 31 32 0 0",
               n_inc, check_count, busy, done);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    #1;
    checks++;
    if (load_input !== 1'b1 || error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL watchdog_restart got load_input=%b err=%b busy=%b exp 1 0 1",
               load_input, error, busy);
    end
    tick();                       // CHECK 1
    end_of_array = 1'b1;
    tick();
    end_of_array = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || sorted !== 1'b1 || check_count !== 6'd1) begin
      failures++;
      $display("FAIL watchdog_rerun got done=%b sorted=%b cnt=%0d exp 1 1 1", done, sorted, check_count);
    end
    $display("test_watchdog done");
  endtask

  initial begin
    test_reset();
    test_sorted();
    test_unsorted();
    test_priority();
    test_abort();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
